// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
module multicycle_control_unit #(
    parameter int OPC_W       = 5,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               inst_ready,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               reg_write,
    output logic               branch,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal,
    output logic               timeout,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_R      = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OP_IALU   = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_BRANCH = OPC_W'(5'b11000);

    // A zero-width counter is not legal, so keep one bit when the timeout is disabled.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [OPC_W-1:0]  opc_q;
    logic [CW-1:0]     wait_cnt;
    logic              in_wait;
    logic              wait_rdy;
    logic              limit_hit;
    logic              dec_legal;
    logic              set_illegal;
    logic              set_timeout;
    logic              is_load;
    logic              is_store;

    assign state    = state_q;
    assign is_load  = (opc_q == OP_LOAD);
    assign is_store = (opc_q == OP_STORE);
    assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wait_rdy = (state_q == S_FETCH) ? inst_ready : mem_ready;

    assign limit_hit = (MEM_TIMEOUT != 0) && in_wait && !wait_rdy &&
                       (wait_cnt == CW'(MEM_TIMEOUT));

    always_comb begin
        dec_legal = 1'b0;
        case (opcode)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH: dec_legal = 1'b1;
            default:                                     dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        branch      = 1'b0;
        alu_op      = '0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                // Ready arriving on the limit cycle takes priority over the trap.
                if (inst_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (limit_hit) begin
                    set_timeout = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_EXEC: begin
                case (opc_q)
                    OP_R: begin
                        alu_op  = ALUOP_W'(2'b10);
                        state_d = S_WB;
                    end
                    OP_IALU: begin
                        alu_src = 1'b1;
                        alu_op  = ALUOP_W'(2'b11);
                        state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        alu_op  = ALUOP_W'(2'b00);
                        state_d = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op  = ALUOP_W'(2'b01);
                        branch  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_ready) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (limit_hit) begin
                    set_timeout = 1'b1;
                    state_d     = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opc_q    <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opc_q <= opcode;
            end
            // Any state change clears the count, so every entry to FETCH/MEM starts at zero.
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (in_wait && !wait_rdy && !limit_hit) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic       inst_ready;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_read, mem_write, mem_to_reg;
    logic       alu_src, reg_write, branch, illegal, timeout;
    logic [1:0] alu_op;
    logic [2:0] state;

    multicycle_control_unit #(
        .OPC_W      (5),
        .ALUOP_W    (2),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .inst_ready(inst_ready),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_to_reg(mem_to_reg),
        .alu_src   (alu_src),
        .reg_write (reg_write),
        .branch    (branch),
        .alu_op    (alu_op),
        .illegal   (illegal),
        .timeout   (timeout),
        .state     (state)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd5;

    // Output vector: {pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src, reg_write, branch, alu_op, illegal, timeout}
    localparam logic [11:0] PCW = 12'h800, IRW = 12'h400, MR  = 12'h200, MW  = 12'h100;
    localparam logic [11:0] M2R = 12'h080, AS  = 12'h040, RW  = 12'h020, BR  = 12'h010;
    localparam logic [11:0] A01 = 12'h004, A10 = 12'h008, A11 = 12'h00C;
    localparam logic [11:0] IL  = 12'h002, TO  = 12'h001, NONE = 12'h000;
    localparam logic [11:0] FGO = PCW | IRW | MR;

    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LD = 5'b00000;
    localparam logic [4:0] OP_ST = 5'b01000, OP_BR = 5'b11000, OP_BAD = 5'b11111;

    typedef struct {
        logic [2:0]  st;
        logic [11:0] o;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [11:0] obs;
    assign obs = {pc_write, ir_write, mem_read, mem_write, mem_to_reg, alu_src,
                  reg_write, branch, alu_op, illegal, timeout};

    task automatic check_one();
        exp_t e;
        e = sb.pop_front();
        vectors++;
        assert ({state, obs} === {e.st, e.o})
        else begin
            miscompares++;
            $error("FAIL %s: observed state=%0d outs=%h expected state=%0d outs=%h",
                   e.tag, state, obs, e.st, e.o);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, queue what this cycle must show, compare 1ns later.
    task automatic cyc(input logic r, input logic ir, input logic mrdy, input logic [4:0] op,
                       input logic [2:0] es, input logic [11:0] eo, input string tag);
        exp_t e;
        rst        = r;
        inst_ready = ir;
        mem_ready  = mrdy;
        opcode     = op;
        e.st  = es;
        e.o   = eo;
        e.tag = tag;
        sb.push_back(e);
        #1;
        check_one();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; inst_ready = 1'b0; mem_ready = 1'b0; opcode = 5'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc(1, 0, 0, OP_R, F, MR, "reset");

        // R-type: 4 cycles
        cyc(0, 1, 0, OP_R, F, FGO, "r_fetch");
        cyc(0, 0, 0, OP_R, D, NONE, "r_decode");
        cyc(0, 0, 0, OP_R, E, A10, "r_exec");
        cyc(0, 0, 0, OP_R, W, RW, "r_wb");

        // LOAD with 3 wait cycles in MEM: 8 cycles
        cyc(0, 1, 0, OP_LD, F, FGO, "ld_fetch");
        cyc(0, 0, 0, OP_LD, D, NONE, "ld_decode");
        cyc(0, 0, 0, OP_LD, E, AS, "ld_exec");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, OP_LD, M, MR, "ld_mem_wait");
        cyc(0, 0, 1, OP_LD, M, MR, "ld_mem_ready");
        cyc(0, 0, 0, OP_LD, W, RW | M2R, "ld_wb");

        // STORE with 2 wait cycles, no writeback
        cyc(0, 1, 0, OP_ST, F, FGO, "st_fetch");
        cyc(0, 0, 0, OP_ST, D, NONE, "st_decode");
        cyc(0, 0, 0, OP_ST, E, AS, "st_exec");
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, OP_ST, M, MW, "st_mem_wait");
        cyc(0, 0, 1, OP_ST, M, MW, "st_mem_ready");

        // I-ALU; opcode input changes during EXEC but the latched copy must rule
        cyc(0, 1, 0, OP_I, F, FGO, "i_fetch");
        cyc(0, 0, 0, OP_I, D, NONE, "i_decode");
        cyc(0, 0, 0, OP_BAD, E, AS | A11, "i_exec_latched");
        cyc(0, 0, 0, OP_BAD, W, RW, "i_wb");

        // BRANCH: 3 cycles
        cyc(0, 1, 0, OP_BR, F, FGO, "br_fetch");
        cyc(0, 0, 0, OP_BR, D, NONE, "br_decode");
        cyc(0, 0, 0, OP_BR, E, BR | A01, "br_exec");

        // Ready on the exact limit cycle wins: 15 waits (count 0..14), ready at count 15
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, OP_R, F, MR, "fetch_wait");
        cyc(0, 1, 0, OP_R, F, FGO, "fetch_ready_at_limit");
        cyc(0, 0, 0, OP_R, D, NONE, "limit_decode");
        cyc(0, 0, 0, OP_R, E, A10, "limit_exec");
        cyc(0, 0, 0, OP_R, W, RW, "limit_wb");

        // Fetch timeout: 16 cycles not ready, then TRAP with timeout set
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, OP_R, F, MR, "fetch_wait_to");
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, OP_R, T, TO, "fetch_trap");
        cyc(1, 0, 0, OP_R, T, TO, "trap_rst_cycle");
        cyc(0, 0, 0, OP_R, F, MR, "after_to_reset");

        // Illegal opcode: absorbing TRAP for 20 cycles, then reset clears it
        cyc(0, 1, 0, OP_BAD, F, FGO, "bad_fetch");
        cyc(0, 0, 0, OP_BAD, D, NONE, "bad_decode");
        for (int i = 0; i < 20; i++) cyc(0, 1, 1, OP_R, T, IL, "bad_trap");
        cyc(1, 0, 0, OP_R, T, IL, "bad_rst_cycle");
        cyc(0, 0, 0, OP_R, F, MR, "after_il_reset");

        // Data memory timeout on LOAD
        cyc(0, 1, 0, OP_LD, F, FGO, "mto_fetch");
        cyc(0, 0, 0, OP_LD, D, NONE, "mto_decode");
        cyc(0, 0, 0, OP_LD, E, AS, "mto_exec");
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, OP_LD, M, MR, "mto_mem_wait");
        cyc(0, 0, 1, OP_LD, T, TO, "mto_trap");
        cyc(1, 0, 0, OP_LD, T, TO, "mto_rst_cycle");

        // Reset mid-instruction: EXEC cycle with rst high, then plain FETCH
        cyc(0, 1, 0, OP_I, F, FGO, "abort_fetch");
        cyc(0, 0, 0, OP_I, D, NONE, "abort_decode");
        cyc(1, 0, 0, OP_I, E, AS | A11, "abort_exec_rst");
        cyc(0, 0, 0, OP_I, F, MR, "abort_fetch_after");
        cyc(0, 0, 0, OP_I, F, MR, "abort_fetch_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
